// File: rtl/timer_ctrl_pkg.sv
// Shared types and defaults for the seconds-timer run controller.
package timer_ctrl_pkg;

  localparam int TIMER_WIDTH_DEF  = 16;
  localparam int WARN_SECONDS_DEF = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    PAUSED  = 3'd3,
    EXPIRED = 3'd4
  } timer_state_t;

endpackage

// File: rtl/timer_ctrl_btn.sv
// Registered rising-edge detector for one debounced button level.
// Previous value resets to 1 so a button held through reset release raises no event.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_edge
);

  logic r_prev;
  logic r_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
      r_edge <= 1'b0;
    end else begin
      r_prev <= i_btn;
      r_edge <= i_btn & ~r_prev;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/timer_ctrl.sv
// Start/pause/stop sequencer and expiry detector in front of a seconds timer.
// Define TIMER_CTRL_WARN_EN to build the registered low-time warning; otherwise o_warning is 0.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int TIMER_WIDTH  = TIMER_WIDTH_DEF,
  parameter int WARN_SECONDS = WARN_SECONDS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_pause_toggle,
  input  logic                   i_stop,
  input  logic [TIMER_WIDTH-1:0] i_limit,
  input  logic [TIMER_WIDTH-1:0] i_current_time,
  output logic                   o_timer_pause,
  output logic                   o_timer_reset,
  output logic [2:0]             o_state,
  output logic [TIMER_WIDTH-1:0] o_remaining,
  output logic                   o_time_up,
  output logic                   o_warning
);

  if (WARN_SECONDS < 0 || WARN_SECONDS >= 2**TIMER_WIDTH) begin : g_bad_warn
    $error("WARN_SECONDS does not fit in TIMER_WIDTH");
  end

  timer_state_t           r_state;
  timer_state_t           w_next;
  logic [TIMER_WIDTH-1:0] r_limit;
  logic [TIMER_WIDTH-1:0] r_remaining;
  logic                   r_stop_rst;
  logic                   r_time_up;
  logic                   w_start;
  logic                   w_pause;
  logic                   w_stop;
  logic                   w_stop_go;
  logic                   w_expire;
  logic                   w_live;
  logic [TIMER_WIDTH-1:0] w_left;

  btn_edge u_start_edge (.clk(clk), .rst_n(rst_n), .i_btn(i_start),        .o_edge(w_start));
  btn_edge u_pause_edge (.clk(clk), .rst_n(rst_n), .i_btn(i_pause_toggle), .o_edge(w_pause));
  btn_edge u_stop_edge  (.clk(clk), .rst_n(rst_n), .i_btn(i_stop),         .o_edge(w_stop));

  always_comb begin
    w_expire  = (i_current_time >= r_limit);
    w_left    = w_expire ? '0 : (r_limit - i_current_time);
    w_live    = (r_state == RUN) || (r_state == PAUSED);
    w_stop_go = w_stop && (r_state != IDLE);
    w_next    = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = ARM;
      ARM:     w_next = (i_limit == '0) ? EXPIRED : RUN;
      RUN: begin
        if (w_expire)     w_next = EXPIRED;
        else if (w_start) w_next = ARM;
        else if (w_pause) w_next = PAUSED;
      end
      PAUSED: begin
        if (w_start)      w_next = ARM;
        else if (w_pause) w_next = RUN;
      end
      EXPIRED: if (w_start) w_next = ARM;
      default: w_next = IDLE;
    endcase
    // Stop overrides every other event, including a same-cycle expiry.
    if (w_stop_go) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_limit     <= '0;
      r_remaining <= '0;
      r_stop_rst  <= 1'b0;
      r_time_up   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_stop_rst  <= w_stop_go;
      r_time_up   <= (w_next == EXPIRED) && (r_state != EXPIRED);
      r_remaining <= w_live ? w_left : '0;
      if (r_state == ARM) r_limit <= i_limit;
    end
  end

`ifdef TIMER_CTRL_WARN_EN
  localparam logic [TIMER_WIDTH-1:0] WARN_TH = TIMER_WIDTH'(WARN_SECONDS);
  logic r_warning;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_warning <= 1'b0;
    else        r_warning <= w_live && (w_left != '0) && (w_left <= WARN_TH);
  end

  assign o_warning = r_warning;
`else
  assign o_warning = 1'b0;
`endif

  assign o_state       = r_state;
  assign o_timer_pause = (r_state != RUN);
  assign o_timer_reset = (r_state == ARM) || r_stop_rst;
  assign o_remaining   = r_remaining;
  assign o_time_up     = r_time_up;

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized bench for timer_ctrl against a cycle-level behavioural model.
module tb_timer_ctrl;

  localparam int W    = 16;
  localparam int WARN = 5;
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_PAUSED = 3, M_EXPIRED = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_pause_toggle = 1'b0;
  logic         i_stop = 1'b0;
  logic [W-1:0] i_limit = '0;
  logic [W-1:0] i_current_time = '0;
  logic         o_timer_pause;
  logic         o_timer_reset;
  logic [2:0]   o_state;
  logic [W-1:0] o_remaining;
  logic         o_time_up;
  logic         o_warning;

  timer_ctrl #(.TIMER_WIDTH(W), .WARN_SECONDS(WARN)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_pause_toggle(i_pause_toggle),
    .i_stop(i_stop), .i_limit(i_limit), .i_current_time(i_current_time),
    .o_timer_pause(o_timer_pause), .o_timer_reset(o_timer_reset), .o_state(o_state),
    .o_remaining(o_remaining), .o_time_up(o_time_up), .o_warning(o_warning)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what the controller should look like after each clock.
  int       m_state, m_limit, m_rem;
  bit [2:0] m_prev, m_evt;   // {stop, pause, start}
  bit       m_tup, m_warn, m_stop_rst;

  task automatic model_reset();
    m_state = M_IDLE; m_limit = 0; m_rem = 0;
    m_prev = 3'b111; m_evt = 3'b000;
    m_tup = 0; m_warn = 0; m_stop_rst = 0;
  endtask

  task automatic model_step();
    bit [2:0] btn;
    int t, nxt, left;
    bit stop_ev, pause_ev, start_ev, live;
    btn      = {i_stop, i_pause_toggle, i_start};
    t        = int'(i_current_time);
    stop_ev  = m_evt[2] && (m_state != M_IDLE);
    pause_ev = m_evt[1];
    start_ev = m_evt[0];
    left     = (m_limit > t) ? m_limit - t : 0;
    nxt      = m_state;
    if (stop_ev)                                nxt = M_IDLE;
    else if (m_state == M_ARM)                  nxt = (i_limit == 0) ? M_EXPIRED : M_RUN;
    else if (m_state == M_RUN && t >= m_limit)  nxt = M_EXPIRED;
    else if (start_ev)                          nxt = M_ARM;
    else if (pause_ev && m_state == M_RUN)      nxt = M_PAUSED;
    else if (pause_ev && m_state == M_PAUSED)   nxt = M_RUN;
    live       = (m_state == M_RUN) || (m_state == M_PAUSED);
    m_stop_rst = stop_ev;
    m_tup      = (nxt == M_EXPIRED) && (m_state != M_EXPIRED);
    m_rem      = live ? left : 0;
`ifdef TIMER_CTRL_WARN_EN
    m_warn     = live && left > 0 && left <= WARN;
`else
    m_warn     = 0;
`endif
    if (m_state == M_ARM) m_limit = int'(i_limit);
    m_evt   = btn & ~m_prev;
    m_prev  = btn;
    m_state = nxt;
  endtask

  task automatic check_all();
    chk("state",     32'(o_state),       32'(m_state));
    chk("pause",     32'(o_timer_pause), 32'(m_state != M_RUN));
    chk("reset",     32'(o_timer_reset), 32'((m_state == M_ARM) || m_stop_rst));
    chk("remaining", 32'(o_remaining),   32'(m_rem));
    chk("time_up",   32'(o_time_up),     32'(m_tup));
    chk("warning",   32'(o_warning),     32'(m_warn));
  endtask

  // Stand-in for the timer instance, following the expected control outputs.
  bit auto_tmr = 1'b1;
  bit jumpy    = 1'b0;
  int tup_seen = 0;

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    tup_seen += int'(o_time_up);
    if (auto_tmr) begin
      if (m_state == M_ARM || m_stop_rst)
        i_current_time = '0;
      else if (m_state == M_RUN)
        i_current_time = i_current_time + W'(jumpy ? $urandom_range(0, 3) : 1);
      else if (m_state == M_PAUSED && jumpy && $urandom_range(0, 15) == 0)
        i_current_time = i_current_time + W'(3);
    end
  endtask

  task automatic pulse(input int which);
    if (which == 0) i_start = 1'b1;
    else if (which == 1) i_pause_toggle = 1'b1;
    else i_stop = 1'b1;
    tick();
    i_start = 1'b0; i_pause_toggle = 1'b0; i_stop = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(o_state) != target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(o_state), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit saw_run;

    // Start held high through reset release must not arm.
    model_reset();
    i_start = 1'b1;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("hold_idle", 32'(o_state), M_IDLE);
    i_start = 1'b0;
    tick();

    // Normal run to expiry with limit 10.
    i_limit = W'(10);
    t0 = tup_seen;
    pulse(0);
    wait_state("arm_reached", M_ARM, 4);
    chk("arm_reset_high", 32'(o_timer_reset), 1);
    tick();
    chk("arm_one_cycle", 32'(o_state), M_RUN);
    wait_state("run_expired", M_EXPIRED, 40);
    repeat (3) tick();
    chk("run_one_tup", 32'(tup_seen - t0), 1);

    // Pause/resume, then stop from PAUSED.
    pulse(0);
    wait_state("restart_run", M_RUN, 6);
    for (int n = 0; n < 20 && i_current_time != W'(4); n++) tick();
    pulse(1);
    wait_state("paused", M_PAUSED, 4);
    repeat (3) tick();
    chk("pause_hold_rem", 32'(o_remaining), 32'(10 - int'(i_current_time)));
    chk("pause_hold_pin", 32'(o_timer_pause), 1);
    pulse(1);
    wait_state("resumed", M_RUN, 4);
    pulse(1);
    wait_state("paused_again", M_PAUSED, 4);
    pulse(2);
    wait_state("stop_idle", M_IDLE, 4);
    chk("stop_reset_pulse", 32'(o_timer_reset), 1);
    tick();
    chk("stop_reset_done", 32'(o_timer_reset), 0);
    chk("stop_rem_zero", 32'(o_remaining), 0);

    // Zero limit goes straight from ARM to EXPIRED.
    i_limit = '0;
    t0 = tup_seen;
    saw_run = 1'b0;
    pulse(0);
    for (int n = 0; n < 8; n++) begin
      tick();
      if (o_state == 3'(M_RUN)) saw_run = 1'b1;
    end
    chk("zero_never_run", 32'(saw_run), 0);
    chk("zero_expired", 32'(o_state), M_EXPIRED);
    chk("zero_one_tup", 32'(tup_seen - t0), 1);

    // Stop and expiry in the same cycle: stop wins, no time-up.
    pulse(2);
    wait_state("zero_stopped", M_IDLE, 4);
    auto_tmr = 1'b0;
    i_limit = W'(3);
    i_current_time = '0;
    pulse(0);
    wait_state("race_run", M_RUN, 6);
    i_current_time = W'(2);
    i_stop = 1'b1;
    tick();
    i_current_time = W'(3);
    t0 = tup_seen;
    repeat (3) tick();
    i_stop = 1'b0;
    chk("race_idle", 32'(o_state), M_IDLE);
    chk("race_no_tup", 32'(tup_seen - t0), 0);

    // Asynchronous reset in the middle of a run.
    auto_tmr = 1'b1;
    i_current_time = '0;
    i_limit = W'(50);
    pulse(0);
    wait_state("arst_run", M_RUN, 6);
    repeat (3) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized button activity, limits and timer jumps.
    jumpy = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0)  i_start = ~i_start;
      if ($urandom_range(0, 7) == 0)  i_pause_toggle = ~i_pause_toggle;
      if ($urandom_range(0, 39) == 0) i_stop = ~i_stop;
      if ($urandom_range(0, 15) == 0) i_limit = W'($urandom_range(0, 20));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Run controller for the seconds `timer`: sequences it through start / pause / resume / stop and detects expiry against a per-round limit. Sits between the debounced button/game-logic inputs and the `timer` instance, and drives that instance's `i_pause` and `i_reset_timer`. Also reports remaining time for display, emits a one-cycle time-up event to game logic and, optionally, a low-time warning.

## Interface
- `TIMER_WIDTH`, 16: width of the time, limit and remaining values; must match the `timer` instance.
- `WARN_SECONDS`, 5: low-time warning threshold, in seconds.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_start`  in  1: start/restart level (debounced); acted on at its rising edge.
- `i_pause_toggle`  in  1: pause/resume level; acted on at its rising edge.
- `i_stop`  in  1: stop level; acted on at its rising edge.
- `i_limit`  in  TIMER_WIDTH: round length in seconds; sampled on start.
- `i_current_time`  in  TIMER_WIDTH: from `timer.o_current_time`.
- `o_timer_pause`  out  1: to `timer.i_pause`.
- `o_timer_reset`  out  1: to `timer.i_reset_timer`.
- `o_state`  out  3: current FSM state, encoded as `timer_state_t`.
- `o_remaining`  out  TIMER_WIDTH: seconds left.
- `o_time_up`  out  1: one-cycle pulse on expiry.
- `o_warning`  out  1: low-time indicator.

## Operation
- Each button has its own rising-edge detector, with previous-value registers reset to 1. A button held high through reset release therefore produces no event.
- The FSM has states IDLE, ARM, RUN, PAUSED and EXPIRED. Reset state is IDLE.
- IDLE
  - start edge → ARM.
  - Other events are ignored.
- ARM (always exactly one cycle)
  - Latches `i_limit` into `limit_q`.
  - If `i_limit == 0` → EXPIRED; otherwise → RUN.
- RUN
  - `i_current_time >= limit_q` → EXPIRED.
  - Otherwise, pause edge → PAUSED.
- PAUSED
  - Pause edge → RUN.
  - Expiry is not checked in PAUSED.
- EXPIRED
  - Start edge → ARM.
- Stop edge in any state except IDLE → IDLE, asserting `o_timer_reset` for that transition cycle.
- Start edge in RUN or PAUSED → ARM (restart).
- Priority when events coincide in one cycle: stop > expiry > start > pause.
- Output decode (Moore, from the state register):
  - `o_timer_pause = 1` in every state except RUN.
  - `o_timer_reset = 1` in ARM, and in the cycle after a stop edge.
- `o_time_up`: registered; high for exactly the first cycle in EXPIRED.
- `o_remaining`, registered:
  - RUN/PAUSED: `limit_q - i_current_time`, saturating at 0 (no wrap when time exceeds the limit).
  - IDLE and EXPIRED: 0.

## Timing
- Reset values:
  - `o_state` = IDLE.
  - `o_timer_pause` = 1.
  - `o_timer_reset` = 0.
  - `o_remaining` = 0.
  - `o_time_up` = 0.
  - `o_warning` = 0.
  - `limit_q` = 0.
- Start sequence:
  - Button rises in cycle N; edge detected at N+1; ARM in N+2, with `o_timer_reset` high.
  - Timer clears at the end of N+2; RUN from N+3, with pause low.
- Expiry reaction:
  - Comparison is against the sampled `i_current_time`.
  - EXPIRED and `o_time_up` appear the cycle after the equality is first seen.
  - `o_timer_pause` is high from that cycle.
- Event latency: pause and stop take effect 2 cycles after the input rises.
- `o_remaining` latency: one cycle behind `i_current_time`.
- Asynchronous reset mid-run returns to IDLE immediately. `o_timer_pause` is forced high; no time-up pulse is emitted.

## Configuration
- `TIMER_CTRL_WARN_EN` defined:
  - `o_warning` is registered.
  - High when state is RUN or PAUSED and `0 < remaining <= WARN_SECONDS`.
  - Otherwise low.
- `TIMER_CTRL_WARN_EN` undefined: `o_warning` is tied to 0 and no comparator logic is built. The port exists in both builds.

## Structure
- Package `timer_ctrl_pkg` holds:
  - `typedef enum logic [2:0] timer_state_t`, with IDLE=0, ARM=1, RUN=2, PAUSED=3, EXPIRED=4.
  - The default `TIMER_WIDTH`.
- Sub-module `btn_edge`: 1-bit rising-edge detector with asynchronous active-low reset and previous-value register reset to 1. Instantiated three times.

## Test plan
- **Hold at reset:** `i_start` held high through reset release → state stays IDLE, `o_timer_pause = 1`, no ARM.
- **Normal run to expiry:** `i_limit = 10`, start pulse, `i_current_time` stepped 0→10 → ARM lasts one cycle with reset high; `o_remaining` shows 10…0; `o_time_up` is high for exactly one cycle; state is EXPIRED.
- **Pause/resume:** pause at time 4 → `o_timer_pause = 1` and `o_remaining = 6` held; pause again → RUN, pause low.
- **Stop from PAUSED:** stop edge → IDLE, one-cycle `o_timer_reset`, `o_remaining = 0`.
- **Zero limit:** `i_limit = 0`, start → ARM then EXPIRED directly; one `o_time_up`; never in RUN.
- **Stop beats expiry; warning:** stop and expiry in the same cycle → IDLE with no `o_time_up`. With `TIMER_CTRL_WARN_EN` and limit 10, `o_warning` rises when remaining = 5 and falls at EXPIRED.
